// File: rtl/softmax_row_sequencer.sv
// softmax_row_sequencer: issues row-buffer reads per row-group command and reports group completion in order
module softmax_row_sequencer #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1,
  parameter int MAX_INFLIGHT = 24,
  parameter int GQ_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [3:0]        i_cmd_mode,
  input  logic [ADDR_W-1:0] i_cmd_base,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_dp_valid,
  output logic [3:0]        o_dp_length_mode,
  output logic              o_dp_first,
  output logic              o_dp_last,
  output logic [3:0]        o_dp_row_idx,
  input  logic              i_dp_ret_valid,
  output logic              o_group_done,
  output logic [3:0]        o_done_mode,
  output logic              o_busy,
  output logic              o_err_mode
);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int PW = $clog2(GQ_DEPTH);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_n;
  logic [3:0] mode_q, mode_n, r_q, r_n, ret_cnt, ret_cnt_n;
  logic [ADDR_W-1:0] base_q, base_n;
  logic [IW-1:0] inflight, inflight_n;
  logic [3:0] gq_mem [GQ_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] gq_cnt, gq_cnt_n;
  logic [10:0] dly [RD_LAT];
  logic [10:0] issue_vec;
  logic busy_q, err_q;
  logic act, issue, last_row, gq_full, acc, legal, push, ret_ok, pop;
  function automatic logic [3:0] rows(input logic [3:0] m);
    return m <= 4'd2 ? 4'd1 : m - 4'd1;
  endfunction
  always_comb begin
    act = i_en & !i_rst;
    issue = act & (state == ISSUE) & (inflight < IW'(MAX_INFLIGHT));
    last_row = r_q == rows(mode_q) - 4'd1;
    gq_full = gq_cnt == (PW+1)'(GQ_DEPTH);
    o_cmd_ready = act & !gq_full & ((state == IDLE) | (issue & last_row));
    acc = i_cmd_valid & o_cmd_ready;
    legal = i_cmd_mode < 4'd14;
    push = acc & legal;
    ret_ok = act & i_dp_ret_valid & (inflight != '0);
    pop = ret_ok & ((ret_cnt + 4'd1) == rows(gq_mem[rd_ptr]));
    state_n = push ? ISSUE : (issue & last_row) ? IDLE : state;
    mode_n = push ? i_cmd_mode : mode_q;
    base_n = push ? i_cmd_base : base_q;
    r_n = push ? 4'd0 : issue ? r_q + 4'd1 : r_q;
    inflight_n = inflight + IW'(issue) - IW'(ret_ok);
    ret_cnt_n = pop ? 4'd0 : ret_cnt + 4'(ret_ok);
    gq_cnt_n = gq_cnt + (PW+1)'(push) - (PW+1)'(pop);
    issue_vec = issue ? {1'b1, mode_q, r_q == 4'd0, last_row, r_q} : '0;
    o_rd_en = issue;
    o_rd_addr = issue ? base_q + ADDR_W'(r_q) : '0;
    o_group_done = pop;
    o_done_mode = pop ? gq_mem[rd_ptr] : '0;
    o_busy = busy_q & !i_rst;
    o_err_mode = err_q & act;
    {o_dp_valid, o_dp_length_mode, o_dp_first, o_dp_last, o_dp_row_idx} = i_rst ? '0 : dly[RD_LAT-1];
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      mode_q <= '0;
      base_q <= '0;
      r_q <= '0;
      inflight <= '0;
      ret_cnt <= '0;
      gq_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
      for (int k = 0; k < RD_LAT; k++) dly[k] <= '0;
    end else begin
      state <= state_n;
      mode_q <= mode_n;
      base_q <= base_n;
      r_q <= r_n;
      inflight <= inflight_n;
      ret_cnt <= ret_cnt_n;
      gq_cnt <= gq_cnt_n;
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      busy_q <= (state_n != IDLE) | (inflight_n != '0) | (gq_cnt_n != '0);
      err_q <= acc & !legal;
      if (i_en) begin
        dly[0] <= issue_vec;
        for (int k = 1; k < RD_LAT; k++) dly[k] <= dly[k-1];
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (push) gq_mem[wr_ptr] <= i_cmd_mode;
  end
endmodule

// File: tb/tb_softmax_row_sequencer.sv
// tb_softmax_row_sequencer: directed scenario tests for softmax_row_sequencer
module tb_softmax_row_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic i_rst, i_en, i_cmd_valid, i_dp_ret_valid;
  logic [3:0] i_cmd_mode;
  logic [9:0] i_cmd_base;
  logic o_cmd_ready, o_rd_en, o_dp_valid, o_dp_first, o_dp_last, o_group_done, o_busy, o_err_mode;
  logic [9:0] o_rd_addr;
  logic [3:0] o_dp_length_mode, o_dp_row_idx, o_done_mode;
  int total = 0, passed = 0;
  int done_at[$];
  logic [3:0] done_md[$];

  softmax_row_sequencer dut (
    .i_clk(clk), .i_rst(i_rst), .i_en(i_en),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_mode(i_cmd_mode), .i_cmd_base(i_cmd_base),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .o_dp_valid(o_dp_valid), .o_dp_length_mode(o_dp_length_mode),
    .o_dp_first(o_dp_first), .o_dp_last(o_dp_last), .o_dp_row_idx(o_dp_row_idx),
    .i_dp_ret_valid(i_dp_ret_valid), .o_group_done(o_group_done),
    .o_done_mode(o_done_mode), .o_busy(o_busy), .o_err_mode(o_err_mode)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] m, input logic [9:0] b);
    cyc();
    i_cmd_valid = 1'b1;
    i_cmd_mode = m;
    i_cmd_base = b;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    done_at.delete();
    done_md.delete();
    for (int i = 1; i <= n; i++) begin
      cyc();
      i_cmd_valid = 1'b0;
      i_dp_ret_valid = 1'b1;
      @(negedge clk);
      if (o_group_done) begin
        done_at.push_back(i);
        done_md.push_back(o_done_mode);
      end
    end
    cyc();
    i_dp_ret_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_en = 1'b1; i_cmd_valid = 1'b0; i_cmd_mode = '0; i_cmd_base = '0; i_dp_ret_valid = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    total++;
    if ({o_cmd_ready, o_rd_en, o_rd_addr, o_dp_valid, o_dp_length_mode, o_dp_first, o_dp_last,
         o_dp_row_idx, o_group_done, o_done_mode, o_busy, o_err_mode} !== 30'd0)
      $display("FAIL reset_outputs: got ready=%b rd_en=%b busy=%b dp_valid=%b, want all 0", o_cmd_ready, o_rd_en, o_busy, o_dp_valid);
    else passed++;
    cyc();
    i_rst = 1'b0;
    @(negedge clk);
    total++;
    if ({o_cmd_ready, o_busy, o_rd_en} !== 3'b100)
      $display("FAIL reset_release: got ready/busy/rd_en=%b, want 100", {o_cmd_ready, o_busy, o_rd_en});
    else passed++;
  endtask

  task automatic test_basic();
    present(4'd3, 10'h010);
    total++;
    if (o_cmd_ready !== 1'b1) $display("FAIL basic_ready: got %b want 1", o_cmd_ready); else passed++;
    cyc(); i_cmd_valid = 1'b0; @(negedge clk);
    total++;
    if ({o_rd_en, o_rd_addr, o_cmd_ready, o_dp_valid} !== {1'b1, 10'h010, 1'b0, 1'b0})
      $display("FAIL basic_row0: got en=%b addr=%h ready=%b dpv=%b want 1 010 0 0", o_rd_en, o_rd_addr, o_cmd_ready, o_dp_valid);
    else passed++;
    cyc(); @(negedge clk);
    total++;
    if ({o_rd_en, o_rd_addr, o_cmd_ready, o_dp_valid, o_dp_length_mode, o_dp_first, o_dp_last, o_dp_row_idx}
        !== {1'b1, 10'h011, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0})
      $display("FAIL basic_row1: got en=%b addr=%h ready=%b dp=%b/%0d/%b/%b/%0d", o_rd_en, o_rd_addr, o_cmd_ready,
               o_dp_valid, o_dp_length_mode, o_dp_first, o_dp_last, o_dp_row_idx);
    else passed++;
    cyc(); @(negedge clk);
    total++;
    if ({o_rd_en, o_busy, o_dp_valid, o_dp_length_mode, o_dp_first, o_dp_last, o_dp_row_idx}
        !== {1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 4'd1})
      $display("FAIL basic_dp1: got en=%b busy=%b dp=%b/%0d/%b/%b/%0d", o_rd_en, o_busy,
               o_dp_valid, o_dp_length_mode, o_dp_first, o_dp_last, o_dp_row_idx);
    else passed++;
    cyc(); @(negedge clk);
    total++;
    if (o_dp_valid !== 1'b0) $display("FAIL basic_dp_idle: got %b want 0", o_dp_valid); else passed++;
    drain(2);
    total++;
    if (done_at.size() != 1 || done_at[0] != 2 || done_md[0] !== 4'd3)
      $display("FAIL basic_done: got %0d pulses, want one at return 2 with mode 3", done_at.size());
    else passed++;
    total++;
    if (o_busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", o_busy); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_addr [17];
    logic exp_ready;
    int bad = 0;
    for (int i = 0; i < 17; i++)
      exp_addr[i] = (i < 2) ? 10'(i) : (i < 14) ? 10'h100 + 10'(i - 2) : 10'h200 + 10'(i - 14);
    present(4'd3, 10'h000);
    for (int c = 1; c <= 17; c++) begin
      cyc();
      if (c <= 2) begin i_cmd_valid = 1'b1; i_cmd_mode = 4'd13; i_cmd_base = 10'h100; end
      else if (c <= 14) begin i_cmd_valid = 1'b1; i_cmd_mode = 4'd4; i_cmd_base = 10'h200; end
      else i_cmd_valid = 1'b0;
      @(negedge clk);
      exp_ready = (c == 2) || (c == 14) || (c == 17);
      total++;
      if ({o_rd_en, o_rd_addr, o_cmd_ready} !== {1'b1, exp_addr[c-1], exp_ready}) begin
        bad++;
        $display("FAIL b2b_cycle%0d: got en=%b addr=%h ready=%b want 1 %h %b", c, o_rd_en, o_rd_addr, o_cmd_ready, exp_addr[c-1], exp_ready);
      end else passed++;
    end
    cyc(); @(negedge clk);
    total++;
    if (o_rd_en !== 1'b0) $display("FAIL b2b_stop: got rd_en=%b want 0", o_rd_en); else passed++;
    drain(17);
    total++;
    if (done_at.size() != 3 || done_at[0] != 2 || done_at[1] != 14 || done_at[2] != 17 ||
        done_md[0] !== 4'd3 || done_md[1] !== 4'd13 || done_md[2] !== 4'd4)
      $display("FAIL b2b_done: got %0d pulses, want at returns 2,14,17 modes 3,13,4", done_at.size());
    else passed++;
  endtask

  task automatic test_wrap();
    logic [9:0] a;
    present(4'd0, 10'h3FF);
    cyc(); i_cmd_valid = 1'b0; @(negedge clk);
    total++;
    if ({o_rd_en, o_rd_addr, o_cmd_ready} !== {1'b1, 10'h3FF, 1'b1})
      $display("FAIL wrap_single: got en=%b addr=%h ready=%b want 1 3ff 1", o_rd_en, o_rd_addr, o_cmd_ready);
    else passed++;
    cyc(); @(negedge clk);
    total++;
    if ({o_rd_en, o_dp_valid, o_dp_length_mode, o_dp_first, o_dp_last, o_dp_row_idx} !== {1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 4'd0})
      $display("FAIL wrap_single_dp: got en=%b dp=%b/%0d/%b/%b/%0d", o_rd_en, o_dp_valid, o_dp_length_mode, o_dp_first, o_dp_last, o_dp_row_idx);
    else passed++;
    drain(1);
    total++;
    if (done_at.size() != 1 || done_md[0] !== 4'd0) $display("FAIL wrap_single_done: got %0d pulses want 1 mode 0", done_at.size());
    else passed++;
    present(4'd13, 10'h3FA);
    for (int i = 0; i < 12; i++) begin
      cyc(); i_cmd_valid = 1'b0; @(negedge clk);
      a = 10'h3FA + 10'(i);
      total++;
      if ({o_rd_en, o_rd_addr} !== {1'b1, a}) $display("FAIL wrap_row%0d: got en=%b addr=%h want 1 %h", i, o_rd_en, o_rd_addr, a);
      else passed++;
    end
    drain(12);
    total++;
    if (done_at.size() != 1 || done_at[0] != 12 || done_md[0] !== 4'd13)
      $display("FAIL wrap_done: got %0d pulses want one at return 12 mode 13", done_at.size());
    else passed++;
  endtask

  task automatic test_illegal();
    present(4'd15, 10'h000);
    total++;
    if (o_cmd_ready !== 1'b1) $display("FAIL err_ready: got %b want 1", o_cmd_ready); else passed++;
    present(4'd4, 10'h020);
    total++;
    if ({o_err_mode, o_rd_en, o_cmd_ready} !== 3'b101)
      $display("FAIL err_pulse: got err/rd_en/ready=%b want 101", {o_err_mode, o_rd_en, o_cmd_ready});
    else passed++;
    for (int i = 0; i < 3; i++) begin
      cyc(); i_cmd_valid = 1'b0; @(negedge clk);
      total++;
      if ({o_err_mode, o_rd_en, o_rd_addr} !== {1'b0, 1'b1, 10'h020 + 10'(i)})
        $display("FAIL err_follow_row%0d: got err=%b en=%b addr=%h", i, o_err_mode, o_rd_en, o_rd_addr);
      else passed++;
    end
    drain(3);
    total++;
    if (done_at.size() != 1 || done_at[0] != 3 || done_md[0] !== 4'd4)
      $display("FAIL err_done: got %0d pulses want one at return 3 mode 4", done_at.size());
    else passed++;
  endtask

  task automatic test_stall();
    logic [9:0] bases [3];
    int accepted = 0, rows = 0, dones = 0, n = 0;
    bases[0] = 10'h000; bases[1] = 10'h040; bases[2] = 10'h080;
    for (int c = 0; c < 40; c++) begin
      cyc();
      i_cmd_valid = accepted < 3;
      i_cmd_mode = 4'd13;
      i_cmd_base = bases[accepted < 3 ? accepted : 2];
      @(negedge clk);
      if (i_cmd_valid && o_cmd_ready) accepted++;
      if (o_rd_en) rows++;
    end
    total++;
    if (rows != 24 || accepted != 3 || o_busy !== 1'b1)
      $display("FAIL stall_limit: got rows=%0d accepted=%0d busy=%b want 24 3 1", rows, accepted, o_busy);
    else passed++;
    cyc(); i_cmd_valid = 1'b0; i_dp_ret_valid = 1'b1; @(negedge clk);
    total++;
    if ({o_rd_en, o_group_done} !== 2'b00) $display("FAIL stall_ret_cycle: got en/done=%b want 00", {o_rd_en, o_group_done});
    else passed++;
    cyc(); i_dp_ret_valid = 1'b0; @(negedge clk);
    total++;
    if ({o_rd_en, o_rd_addr} !== {1'b1, 10'h080}) $display("FAIL stall_resume: got en=%b addr=%h want 1 080", o_rd_en, o_rd_addr);
    else passed++;
    for (int k = 2; k <= 12; k++) begin
      cyc(); i_dp_ret_valid = 1'b1; @(negedge clk);
      total++;
      if ({o_group_done, o_done_mode} !== ((k == 12) ? {1'b1, 4'd13} : 5'd0))
        $display("FAIL stall_done_ret%0d: got done=%b mode=%0d", k, o_group_done, o_done_mode);
      else passed++;
    end
    while (n < 100) begin
      cyc(); i_dp_ret_valid = 1'b1; @(negedge clk);
      n++;
      if (o_group_done) dones++;
      if (!o_busy) break;
    end
    cyc(); i_dp_ret_valid = 1'b0;
    total++;
    if (o_busy !== 1'b0 || dones != 2) $display("FAIL stall_drain: got busy=%b dones=%0d want 0 2", o_busy, dones);
    else passed++;
  endtask

  task automatic test_freeze();
    present(4'd13, 10'h100);
    for (int c = 1; c <= 4; c++) begin
      cyc(); i_cmd_valid = 1'b0; @(negedge clk);
      total++;
      if ({o_rd_en, o_rd_addr} !== {1'b1, 10'h100 + 10'(c - 1)}) $display("FAIL freeze_pre%0d: got en=%b addr=%h", c, o_rd_en, o_rd_addr);
      else passed++;
    end
    for (int c = 5; c <= 9; c++) begin
      cyc(); i_en = 1'b0; i_dp_ret_valid = 1'b1; @(negedge clk);
      total++;
      if ({o_rd_en, o_cmd_ready, o_dp_valid, o_dp_row_idx, o_busy, o_group_done} !== {1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0})
        $display("FAIL freeze_hold%0d: got en=%b ready=%b dpv=%b idx=%0d busy=%b done=%b", c, o_rd_en, o_cmd_ready, o_dp_valid, o_dp_row_idx, o_busy, o_group_done);
      else passed++;
    end
    for (int c = 10; c <= 17; c++) begin
      cyc(); i_en = 1'b1; i_dp_ret_valid = 1'b0; @(negedge clk);
      total++;
      if ({o_rd_en, o_rd_addr, o_dp_row_idx} !== {1'b1, 10'h100 + 10'(c - 6), (c == 10) ? 4'd3 : 4'(c - 7)})
        $display("FAIL freeze_resume%0d: got en=%b addr=%h idx=%0d", c, o_rd_en, o_rd_addr, o_dp_row_idx);
      else passed++;
    end
    drain(12);
    total++;
    if (done_at.size() != 1 || done_at[0] != 12 || done_md[0] !== 4'd13)
      $display("FAIL freeze_done: got %0d pulses want one at return 12 mode 13", done_at.size());
    else passed++;
  endtask

  task automatic test_reset_mid();
    present(4'd13, 10'h200);
    for (int c = 1; c <= 3; c++) begin cyc(); i_cmd_valid = 1'b0; @(negedge clk); end
    cyc(); i_rst = 1'b1; @(negedge clk);
    total++;
    if ({o_cmd_ready, o_rd_en, o_rd_addr, o_dp_valid, o_dp_length_mode, o_dp_first, o_dp_last,
         o_dp_row_idx, o_group_done, o_done_mode, o_busy, o_err_mode} !== 30'd0)
      $display("FAIL rstmid_outputs: got ready=%b en=%b dpv=%b busy=%b want all 0", o_cmd_ready, o_rd_en, o_dp_valid, o_busy);
    else passed++;
    cyc(); i_rst = 1'b0; @(negedge clk);
    total++;
    if ({o_busy, o_rd_en, o_cmd_ready, o_dp_valid} !== 4'b0010)
      $display("FAIL rstmid_after: got busy/en/ready/dpv=%b want 0010", {o_busy, o_rd_en, o_cmd_ready, o_dp_valid});
    else passed++;
    drain(1);
    total++;
    if (done_at.size() != 0) $display("FAIL rstmid_no_done: got %0d pulses want 0", done_at.size()); else passed++;
    present(4'd3, 10'h050);
    cyc(); i_cmd_valid = 1'b0; cyc(); cyc();
    drain(2);
    total++;
    if (done_at.size() != 1 || done_at[0] != 2 || done_md[0] !== 4'd3 || o_busy !== 1'b0)
      $display("FAIL rstmid_fifo_empty: got %0d pulses busy=%b want one at return 2 mode 3", done_at.size(), o_busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_wrap();
    test_illegal();
    test_stall();
    test_freeze();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
